// File: rtl/iic_pkg.sv
// Shared types for the IIC register-initialisation sequencer: FSM state
// encoding and the 25-bit ROM entry layout {addr_mode, reg_addr, data}.
package iic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PWR_WAIT,
    LOAD,
    REQ,
    WAIT_DONE,
    GAP,
    DONE,
    ERROR
  } state_t;

  localparam int ENTRY_W = 25;

  typedef struct packed {
    logic        addr_mode;
    logic [15:0] reg_addr;
    logic [7:0]  data;
  } rom_entry_t;

  function automatic rom_entry_t mk_entry(input logic am, input logic [15:0] ra,
                                          input logic [7:0] d);
    rom_entry_t e;
    e.addr_mode = am;
    e.reg_addr  = ra;
    e.data      = d;
    return e;
  endfunction

endpackage

// File: rtl/iic_init_rom.sv
// Project-specific register table: combinational idx -> {addr_mode, reg_addr, data}.
// Unlisted indices read as all-zero.
module iic_init_rom
  import iic_pkg::*;
(
  input  logic [7:0] idx,
  output rom_entry_t entry
);

  always_comb begin
    entry = '0;
    case (idx)
      8'd0:    entry = mk_entry(1'b1, 16'h3008, 8'h82);
      8'd1:    entry = mk_entry(1'b0, 16'h0012, 8'h80);
      8'd2:    entry = mk_entry(1'b1, 16'h3103, 8'h03);
      8'd3:    entry = mk_entry(1'b1, 16'h3017, 8'hFF);
      8'd4:    entry = mk_entry(1'b1, 16'h3018, 8'hFF);
      8'd5:    entry = mk_entry(1'b1, 16'h3034, 8'h1A);
      8'd6:    entry = mk_entry(1'b1, 16'h3035, 8'h11);
      8'd7:    entry = mk_entry(1'b1, 16'h3036, 8'h46);
      8'd8:    entry = mk_entry(1'b1, 16'h3037, 8'h13);
      8'd9:    entry = mk_entry(1'b1, 16'h3108, 8'h01);
      8'd10:   entry = mk_entry(1'b1, 16'h3630, 8'h36);
      8'd11:   entry = mk_entry(1'b1, 16'h3631, 8'h0E);
      8'd12:   entry = mk_entry(1'b1, 16'h3632, 8'hE2);
      8'd13:   entry = mk_entry(1'b1, 16'h3633, 8'h12);
      8'd14:   entry = mk_entry(1'b0, 16'h0040, 8'h2C);
      8'd15:   entry = mk_entry(1'b1, 16'h3008, 8'h02);
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/iic_init_seq.sv
// Register-initialisation sequencer driving the iic_ctrl write port.
// Define IIC_INIT_RETRY_EN to retry a failed entry up to MAX_RETRY times.
module iic_init_seq
  import iic_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID = 8'h60,
  parameter int         NUM_REGS  = 16,
  parameter int         PWR_DLY   = 50000,
  parameter int         GAP_DLY   = 1000,
  parameter int         TIMEOUT   = 200000,
  parameter int         MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [7:0]  err_idx,
  output logic        w_req,
  output logic [7:0]  device_id,
  output logic [15:0] reg_addr,
  output logic        addr_mode,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        ack
);

  localparam int PW = $clog2(PWR_DLY + 1);
  localparam int GW = $clog2(GAP_DLY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(PWR_DLY - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_DLY - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]    IDX_LAST = 8'(NUM_REGS - 1);

  state_t          state_reg;
  logic [7:0]      idx_reg;
  logic [PW-1:0]   pwr_cnt_reg;
  logic [GW-1:0]   gap_cnt_reg;
  logic [TW-1:0]   to_cnt_reg;
  rom_entry_t      rom_entry;
  logic            to_hit;

`ifdef IIC_INIT_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0]   retry_cnt_reg;
  logic            retry_pend_reg;
`endif

  iic_init_rom u_rom (
    .idx   (idx_reg),
    .entry (rom_entry)
  );

  assign device_id = DEVICE_ID;
  assign to_hit    = (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= PWR_WAIT;
      idx_reg     <= '0;
      pwr_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      busy        <= 1'b0;
      init_done   <= 1'b0;
      init_err    <= 1'b0;
      err_idx     <= '0;
      w_req       <= 1'b0;
      reg_addr    <= '0;
      addr_mode   <= 1'b0;
      wr_data     <= '0;
`ifdef IIC_INIT_RETRY_EN
      retry_cnt_reg  <= '0;
      retry_pend_reg <= 1'b0;
`endif
    end else begin
      w_req <= 1'b0;
      case (state_reg)
        PWR_WAIT: begin
          if (pwr_cnt_reg == PWR_LAST) begin
            idx_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= LOAD;
          end else begin
            pwr_cnt_reg <= pwr_cnt_reg + 1'b1;
          end
        end
        IDLE, DONE, ERROR: begin
          if (start) begin
            init_done <= 1'b0;
            init_err  <= 1'b0;
            idx_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= LOAD;
`ifdef IIC_INIT_RETRY_EN
            retry_cnt_reg  <= '0;
            retry_pend_reg <= 1'b0;
`endif
          end
        end
        LOAD: begin
          addr_mode <= rom_entry.addr_mode;
          reg_addr  <= rom_entry.reg_addr;
          wr_data   <= rom_entry.data;
          state_reg <= REQ;
        end
        REQ: begin
          w_req      <= 1'b1;
          to_cnt_reg <= '0;
          state_reg  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A completion pulse wins over a timeout landing in the same cycle.
          if (wr_done && !ack) begin
            state_reg <= GAP;
`ifdef IIC_INIT_RETRY_EN
            retry_cnt_reg <= '0;
`endif
          end else if (wr_done || to_hit) begin
`ifdef IIC_INIT_RETRY_EN
            if (retry_cnt_reg < RETRY_MAX) begin
              retry_cnt_reg  <= retry_cnt_reg + 1'b1;
              retry_pend_reg <= 1'b1;
              state_reg      <= GAP;
            end else begin
              err_idx   <= idx_reg;
              init_err  <= 1'b1;
              busy      <= 1'b0;
              state_reg <= ERROR;
            end
`else
            err_idx   <= idx_reg;
            init_err  <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ERROR;
`endif
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
`ifdef IIC_INIT_RETRY_EN
            if (retry_pend_reg) begin
              retry_pend_reg <= 1'b0;
              state_reg      <= REQ;
            end else
`endif
            if (idx_reg == IDX_LAST) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg + 8'd1;
              state_reg <= LOAD;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_init_seq.sv
// Scoreboard bench for iic_init_seq with a small iic_ctrl responder model.
// Honours IIC_INIT_RETRY_EN so expectations follow the build being tested.
module tb_iic_init_seq;

  localparam int NUM_REGS  = 3;
  localparam int PWR_DLY   = 10;
  localparam int GAP_DLY   = 4;
  localparam int TIMEOUT   = 50;
  localparam int MAX_RETRY = 2;
  localparam int RESP_LAT  = 6;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        init_done;
  logic        init_err;
  logic [7:0]  err_idx;
  logic        w_req;
  logic [7:0]  device_id;
  logic [15:0] reg_addr;
  logic        addr_mode;
  logic [7:0]  wr_data;
  logic        wr_done;
  logic        ack;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int wreq_cnt      = 0;
  int last_wreq_cyc = 0;
  int last_done_cyc = 0;
  int rel_cyc       = 0;

  logic [24:0] exp_q[$];
  int          plan_q[$];   // per request: 0 = ACK, 1 = NACK, 2 = no response

  iic_init_seq #(
    .DEVICE_ID (8'h60),
    .NUM_REGS  (NUM_REGS),
    .PWR_DLY   (PWR_DLY),
    .GAP_DLY   (GAP_DLY),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .init_done (init_done),
    .init_err  (init_err),
    .err_idx   (err_idx),
    .w_req     (w_req),
    .device_id (device_id),
    .reg_addr  (reg_addr),
    .addr_mode (addr_mode),
    .wr_data   (wr_data),
    .wr_done   (wr_done),
    .ack       (ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [24:0] rom_val(input int i);
    logic [24:0] v;
    case (i)
      0:       v = {1'b1, 16'h3008, 8'h82};
      1:       v = {1'b0, 16'h0012, 8'h80};
      2:       v = {1'b1, 16'h3103, 8'h03};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int idx);
    exp_q.push_back(rom_val(idx));
  endtask

  task automatic wait_wreq(input int n, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (wreq_cnt >= n) return;
    end
    chk("wait_wreq_timeout", 32'(wreq_cnt), 32'(n));
  endtask

  task automatic wait_status(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (init_done || init_err) return;
    end
    chk("wait_status_timeout", {30'd0, init_done, init_err}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_init_err"},  32'(init_err), 32'd0);
    chk({tag, "_w_req"},     32'(w_req), 32'd0);
    chk({tag, "_err_idx"},   32'(err_idx), 32'd0);
    chk({tag, "_reg_addr"},  32'(reg_addr), 32'd0);
    chk({tag, "_wr_data"},   32'(wr_data), 32'd0);
    chk({tag, "_addr_mode"}, 32'(addr_mode), 32'd0);
  endtask

  // Monitor: every w_req must match the next scoreboard entry.
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (w_req) begin
        wreq_cnt++;
        last_wreq_cyc = cyc;
        $display("wreq cyc=%0d mode=%0d addr=%04h data=%02h dev=%02h",
                 cyc, addr_mode, reg_addr, wr_data, device_id);
        if (exp_q.size() == 0) begin
          chk("unexpected_wreq", {7'd0, addr_mode, reg_addr, wr_data}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wreq_entry", {7'd0, addr_mode, reg_addr, wr_data}, {7'd0, e});
        end
        chk("wreq_device_id", 32'(device_id), 32'h60);
      end
    end
  end

  // iic_ctrl model: answers each write after RESP_LAT cycles per the plan.
  initial begin
    int code;
    wr_done = 1'b0;
    ack     = 1'b0;
    forever begin
      @(negedge clk);
      if (w_req) begin
        code = (plan_q.size() != 0) ? plan_q.pop_front() : 0;
        if (code != 2) begin
          repeat (RESP_LAT - 1) @(negedge clk);
          wr_done = 1'b1;
          ack     = (code == 1);
          last_done_cyc = cyc;
          @(negedge clk);
          wr_done = 1'b0;
          ack     = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    chk("device_id", 32'(device_id), 32'h60);

    // Nominal run with an ignored mid-run start.
    for (int i = 0; i < NUM_REGS; i++) push_exp(i);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    wait_wreq(1, 100);
    chk("pwr_wait_latency", 32'(last_wreq_cyc - rel_cyc), 32'(PWR_DLY + 2));
    pulse_start();
    wait_status(500);
    chk("run1_done_latency", 32'(cyc - last_done_cyc), 32'(GAP_DLY + 1));
    chk("run1_init_done", 32'(init_done), 32'd1);
    chk("run1_busy", 32'(busy), 32'd0);
    chk("run1_init_err", 32'(init_err), 32'd0);
    repeat (20) @(negedge clk);
    chk("run1_wreq_cnt", 32'(wreq_cnt), 32'd3);
    chk("run1_exp_left", 32'(exp_q.size()), 32'd0);

    // Re-run after DONE: init_done drops at the pulse.
    wreq_cnt = 0;
    for (int i = 0; i < NUM_REGS; i++) push_exp(i);
    pulse_start();
    chk("run2_init_done_cleared", 32'(init_done), 32'd0);
    chk("run2_busy", 32'(busy), 32'd1);
    wait_status(500);
    chk("run2_init_done", 32'(init_done), 32'd1);
    repeat (20) @(negedge clk);
    chk("run2_wreq_cnt", 32'(wreq_cnt), 32'd3);

    // NACK on entry 1.
    wreq_cnt = 0;
`ifdef IIC_INIT_RETRY_EN
    plan_q = '{0, 1, 1, 0, 0};
    push_exp(0); push_exp(1); push_exp(1); push_exp(1); push_exp(2);
`else
    plan_q = '{0, 1};
    push_exp(0); push_exp(1);
`endif
    pulse_start();
    wait_status(1000);
    repeat (40) @(negedge clk);
`ifdef IIC_INIT_RETRY_EN
    chk("nack_init_done", 32'(init_done), 32'd1);
    chk("nack_init_err", 32'(init_err), 32'd0);
    chk("nack_wreq_cnt", 32'(wreq_cnt), 32'd5);
`else
    chk("nack_init_err", 32'(init_err), 32'd1);
    chk("nack_err_idx", 32'(err_idx), 32'd1);
    chk("nack_init_done", 32'(init_done), 32'd0);
    chk("nack_busy", 32'(busy), 32'd0);
    chk("nack_wreq_cnt", 32'(wreq_cnt), 32'd2);
`endif
    chk("nack_exp_left", 32'(exp_q.size()), 32'd0);

    // Timeout: iic_ctrl never answers.
    wreq_cnt = 0;
`ifdef IIC_INIT_RETRY_EN
    plan_q = '{2, 2, 2};
    push_exp(0); push_exp(0); push_exp(0);
`else
    plan_q = '{2};
    push_exp(0);
`endif
    pulse_start();
    wait_status(1000);
    chk("to_init_err", 32'(init_err), 32'd1);
    chk("to_latency", 32'(cyc - last_wreq_cyc), 32'(TIMEOUT));
    chk("to_err_idx", 32'(err_idx), 32'd0);
`ifdef IIC_INIT_RETRY_EN
    chk("to_wreq_cnt", 32'(wreq_cnt), 32'd3);
`else
    chk("to_wreq_cnt", 32'(wreq_cnt), 32'd1);
`endif

    // Asynchronous reset while waiting on entry 2, then automatic restart.
    wreq_cnt = 0;
    plan_q = '{0, 0, 2};
    for (int i = 0; i < NUM_REGS; i++) push_exp(i);
    pulse_start();
    wait_wreq(3, 500);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    wreq_cnt = 0;
    for (int i = 0; i < NUM_REGS; i++) push_exp(i);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    wait_wreq(1, 100);
    chk("restart_latency", 32'(last_wreq_cyc - rel_cyc), 32'(PWR_DLY + 2));
    wait_status(500);
    chk("restart_init_done", 32'(init_done), 32'd1);
    chk("restart_init_err", 32'(init_err), 32'd0);
    repeat (20) @(negedge clk);
    chk("restart_wreq_cnt", 32'(wreq_cnt), 32'd3);
    chk("restart_exp_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
